// File: rtl/risc_v_mike_pkg.sv
// risc_v_mike_pkg: shared types and constants for the risc_v_mike core.
//   DATA_32_W    datapath width
//   DMEM_WAIT_W  width of the data memory wait-state counter
//   mem_size_t   access size encoding used on req_size
//   dmem_state_t data memory controller FSM states
`timescale 1ns/1ps
package risc_v_mike_pkg;

  localparam int unsigned DATA_32_W   = 32;
  localparam int unsigned DMEM_WAIT_W = 4;

  typedef enum logic [1:0] {
    MEM_BYTE    = 2'b00,
    MEM_HALF    = 2'b01,
    MEM_WORD    = 2'b10,
    MEM_ILLEGAL = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'b00,
    DMEM_WAIT = 2'b01,
    DMEM_RESP = 2'b10
  } dmem_state_t;

endpackage

// File: rtl/risc_v_mike_dmem_lane.sv
// risc_v_mike_dmem_lane: combinational byte-lane steering for the data memory.
//   size_i        access size (mem_size_t)
//   off_i         byte offset within the word (addr[1:0])
//   unsigned_i    loads: 1 = zero-extend, 0 = sign-extend
//   wdata_i       right-aligned store data
//   word_rdata_i  addressed storage word
//   be_o          byte enables for stores
//   wdata_o       store data replicated onto every lane
//   rdata_o       extracted and extended load data
//   size_err_o    illegal size encoding
//   align_err_o   misaligned half/word (only with RISC_V_MIKE_DMEM_MISALIGN_ERR_EN;
//                 otherwise misaligned addresses are aligned down)
`timescale 1ns/1ps
module risc_v_mike_dmem_lane
  import risc_v_mike_pkg::*;
(
  input  mem_size_t              size_i,
  input  logic [1:0]             off_i,
  input  logic                   unsigned_i,
  input  logic [DATA_32_W-1:0]   wdata_i,
  input  logic [DATA_32_W-1:0]   word_rdata_i,
  output logic [3:0]             be_o,
  output logic [DATA_32_W-1:0]   wdata_o,
  output logic [DATA_32_W-1:0]   rdata_o,
  output logic                   size_err_o,
  output logic                   align_err_o
);

  logic [1:0]           off;
  logic [DATA_32_W-1:0] sh;

  always_comb begin
    be_o        = '0;
    wdata_o     = wdata_i;
    rdata_o     = '0;
    size_err_o  = 1'b0;
    align_err_o = 1'b0;
    off         = '0;
    sh          = '0;

    case (size_i)
      MEM_BYTE: begin
        off     = off_i;
        be_o    = 4'b0001 << off;
        wdata_o = {4{wdata_i[7:0]}};
      end
      MEM_HALF: begin
        off     = {off_i[1], 1'b0};
        be_o    = 4'b0011 << off;
        wdata_o = {2{wdata_i[15:0]}};
`ifdef RISC_V_MIKE_DMEM_MISALIGN_ERR_EN
        align_err_o = off_i[0];
`endif
      end
      MEM_WORD: begin
        off  = '0;
        be_o = 4'b1111;
`ifdef RISC_V_MIKE_DMEM_MISALIGN_ERR_EN
        align_err_o = |off_i;
`endif
      end
      default: size_err_o = 1'b1;
    endcase

    // Shift the selected lane(s) down to bit 0, then extend.
    sh = word_rdata_i >> {off, 3'b000};
    case (size_i)
      MEM_BYTE: rdata_o = unsigned_i ? {24'b0, sh[7:0]}   : {{24{sh[7]}}, sh[7:0]};
      MEM_HALF: rdata_o = unsigned_i ? {16'b0, sh[15:0]}  : {{16{sh[15]}}, sh[15:0]};
      MEM_WORD: rdata_o = sh;
      default:  rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/risc_v_mike_data_memory_ctrl.sv
// risc_v_mike_data_memory_ctrl: handshaked byte/half/word data memory.
//   DATA_MEM_DEPTH  number of 32-bit words (power of two, >= 2)
//   WAIT_STATES     extra cycles between accept and response (0..15)
//   clk, rst        clock, asynchronous active-high reset
//   req_*           request channel (valid/ready), captured on accept
//   rsp_*           response channel, held stable until rsp_ready
// Optional macro RISC_V_MIKE_DMEM_MISALIGN_ERR_EN turns misaligned half/word
// accesses into errors instead of aligning them down.
`timescale 1ns/1ps
module risc_v_mike_data_memory_ctrl
  import risc_v_mike_pkg::*;
#(
  parameter int unsigned DATA_MEM_DEPTH = 64,
  parameter int unsigned WAIT_STATES    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [DATA_32_W-1:0] req_addr,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [DATA_32_W-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_32_W-1:0] rsp_rdata,
  output logic                 rsp_err
);

  localparam int unsigned IDX_W = $clog2(DATA_MEM_DEPTH);
  localparam logic [DMEM_WAIT_W-1:0] WAIT_LOAD =
    (WAIT_STATES == 0) ? '0 : DMEM_WAIT_W'(WAIT_STATES - 1);

  dmem_state_t            state_q, state_d;
  logic [DMEM_WAIT_W-1:0] cnt_q, cnt_d;

  logic                   rq_write_q;
  logic [DATA_32_W-1:0]   rq_addr_q;
  mem_size_t              rq_size_q;
  logic                   rq_unsigned_q;
  logic [DATA_32_W-1:0]   rq_wdata_q;

  logic [DATA_32_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                   rsp_err_q, rsp_err_d;

  logic [DATA_32_W-1:0]   mem_q [DATA_MEM_DEPTH];

  logic                   accept;
  logic                   enter_resp;
  logic                   acc_write;
  logic [DATA_32_W-1:0]   acc_addr;
  mem_size_t              acc_size;
  logic                   acc_unsigned;
  logic [DATA_32_W-1:0]   acc_wdata;
  logic [IDX_W-1:0]       idx;
  logic                   range_err;
  logic                   acc_err;
  logic                   mem_we;

  logic [3:0]             lane_be;
  logic [DATA_32_W-1:0]   lane_wdata;
  logic [DATA_32_W-1:0]   lane_rdata;
  logic                   size_err;
  logic                   align_err;

  assign req_ready = (state_q == DMEM_IDLE) & ~rst;
  assign accept    = req_valid & req_ready;
  assign rsp_valid = (state_q == DMEM_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // With no wait states the access happens on the accepting edge, before the
  // request register is loaded, so the live request feeds the datapath in IDLE.
  always_comb begin
    if (state_q == DMEM_IDLE) begin
      acc_write    = req_write;
      acc_addr     = req_addr;
      acc_size     = mem_size_t'(req_size);
      acc_unsigned = req_unsigned;
      acc_wdata    = req_wdata;
    end else begin
      acc_write    = rq_write_q;
      acc_addr     = rq_addr_q;
      acc_size     = rq_size_q;
      acc_unsigned = rq_unsigned_q;
      acc_wdata    = rq_wdata_q;
    end
  end

  assign idx       = acc_addr[IDX_W+1:2];
  assign range_err = |acc_addr[DATA_32_W-1:IDX_W+2];
  assign acc_err   = range_err | size_err | align_err;

  risc_v_mike_dmem_lane u_lane (
    .size_i       (acc_size),
    .off_i        (acc_addr[1:0]),
    .unsigned_i   (acc_unsigned),
    .wdata_i      (acc_wdata),
    .word_rdata_i (mem_q[idx]),
    .be_o         (lane_be),
    .wdata_o      (lane_wdata),
    .rdata_o      (lane_rdata),
    .size_err_o   (size_err),
    .align_err_o  (align_err)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    enter_resp  = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      DMEM_IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_d    = DMEM_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = DMEM_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      DMEM_WAIT: begin
        if (cnt_q == '0) begin
          state_d    = DMEM_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - DMEM_WAIT_W'(1);
        end
      end
      DMEM_RESP: begin
        if (rsp_ready) state_d = DMEM_IDLE;
      end
      default: state_d = DMEM_IDLE;
    endcase

    if (enter_resp) begin
      rsp_err_d   = acc_err;
      rsp_rdata_d = (acc_err | acc_write) ? '0 : lane_rdata;
    end
  end

  assign mem_we = enter_resp & acc_write & ~acc_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= DMEM_IDLE;
      cnt_q         <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rq_write_q    <= 1'b0;
      rq_addr_q     <= '0;
      rq_size_q     <= MEM_BYTE;
      rq_unsigned_q <= 1'b0;
      rq_wdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      if (accept) begin
        rq_write_q    <= req_write;
        rq_addr_q     <= req_addr;
        rq_size_q     <= mem_size_t'(req_size);
        rq_unsigned_q <= req_unsigned;
        rq_wdata_q    <= req_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DATA_MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (lane_be[b]) mem_q[idx][8*b +: 8] <= lane_wdata[8*b +: 8];
      end
    end
  end

endmodule
